// File: rtl/common_pkg.sv
// Shared rename/dispatch types and sizing constants.
// Consumers may build with RENAME_FLUSH_EN to enable flush recovery.
package common_pkg;

    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned PREG_W    = $clog2(NUM_PREGS);
    localparam int unsigned FL_DEPTH  = NUM_PREGS - ARCH_REGS;
    localparam int unsigned AREG_W    = 5;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [AREG_W-1:0] rs1;
        logic [AREG_W-1:0] rs2;
        logic [AREG_W-1:0] rd;
        logic              has_rd;
    } decode_packet_t;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [PREG_W-1:0] p_src1;
        logic [PREG_W-1:0] p_src2;
        logic [PREG_W-1:0] p_dst;
        logic [PREG_W-1:0] p_old_dst;
        logic [AREG_W-1:0] arch_rd;
        logic              has_rd;
    } dispatch_packet_t;

    // x0 is hardwired, so it never consumes a physical tag.
    function automatic logic writes_reg(input logic has_rd, input logic [AREG_W-1:0] rd);
        return has_rd && (rd != '0);
    endfunction

endpackage

// File: rtl/rename_stage_free_list.sv
// Circular FIFO of free physical tags, reset-filled with ARCH_REGS..NUM_PREGS-1.
// With RENAME_FLUSH_EN it tracks a retire head for flush recovery.
module free_list
    import common_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pop,
    output logic [PREG_W-1:0] pop_tag,
    input  logic              push,
    input  logic [PREG_W-1:0] push_tag,
`ifdef RENAME_FLUSH_EN
    input  logic              flush,
`endif
    output logic [PREG_W-1:0] count
);

    localparam int unsigned IDX_W = PREG_W - 1;
`ifdef RENAME_FLUSH_EN
    // Tail and retire head carry a wrap bit so a full list is distinguishable on restore.
    localparam int unsigned TAIL_W = PREG_W;
`else
    localparam int unsigned TAIL_W = IDX_W;
`endif

    logic [PREG_W-1:0] mem_q [FL_DEPTH];
    logic [IDX_W-1:0]  head_q, head_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic [PREG_W-1:0] count_q, count_d;
`ifdef RENAME_FLUSH_EN
    logic [TAIL_W-1:0] retire_q, retire_d;
`endif

    assign pop_tag = mem_q[head_q];
    assign count   = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + PREG_W'(push) - PREG_W'(pop);
        if (pop)  head_d = head_q + 1'b1;
        if (push) tail_d = tail_q + 1'b1;
`ifdef RENAME_FLUSH_EN
        retire_d = retire_q;
        if (push) retire_d = retire_q + 1'b1;
        if (flush) begin
            head_d  = retire_d[IDX_W-1:0];
            count_d = tail_d - retire_d;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= TAIL_W'(FL_DEPTH);
            count_q <= PREG_W'(FL_DEPTH);
`ifdef RENAME_FLUSH_EN
            retire_q <= '0;
`endif
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
`ifdef RENAME_FLUSH_EN
            retire_q <= retire_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= PREG_W'(ARCH_REGS + i);
            end
        end else if (push) begin
            mem_q[tail_q[IDX_W-1:0]] <= push_tag;
        end
    end

`ifndef SYNTHESIS
    overflow_a: assert property (@(posedge clk) disable iff (!reset)
        (push && !pop) |-> (count_q < PREG_W'(FL_DEPTH)));
`endif

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: speculative RAT + free list feeding one registered dispatch slot.
// Build with RENAME_FLUSH_EN to add the flush port, retirement RAT and restore path.
module rename_stage
    import common_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_valid,
    input  decode_packet_t      dec_pkt,
    output logic                dec_ready,
    output logic                rename_valid,
    output dispatch_packet_t    rename_pkt,
    input  logic                dispatch_ready,
    input  logic                commit_valid,
    input  logic                commit_has_rd,
    input  logic [AREG_W-1:0]   commit_arch_rd,
    input  logic [PREG_W-1:0]   commit_p_dst,
    input  logic [PREG_W-1:0]   commit_p_old
`ifdef RENAME_FLUSH_EN
    ,
    input  logic                flush
`endif
);

    logic [PREG_W-1:0] rat_q [ARCH_REGS];
    logic [PREG_W-1:0] rat_d [ARCH_REGS];
`ifdef RENAME_FLUSH_EN
    logic [PREG_W-1:0] rrat_q [ARCH_REGS];
    logic [PREG_W-1:0] rrat_d [ARCH_REGS];
`endif
    logic              rename_valid_q, rename_valid_d;
    dispatch_packet_t  rename_pkt_q, rename_pkt_d;
    logic              need_rd, accept, fl_push;
    logic [PREG_W-1:0] fl_tag, fl_count;

    assign need_rd      = writes_reg(dec_pkt.has_rd, dec_pkt.rd);
    assign fl_push      = commit_valid && commit_has_rd && (commit_arch_rd != '0);
    assign accept       = dec_valid && dec_ready;
    assign rename_valid = rename_valid_q;
    assign rename_pkt   = rename_pkt_q;

    always_comb begin
        dec_ready = reset && (!rename_valid_q || dispatch_ready) && (!need_rd || (fl_count != '0));
`ifdef RENAME_FLUSH_EN
        if (flush) dec_ready = 1'b0;
`endif
    end

    free_list u_free_list (
        .clk      (clk),
        .reset    (reset),
        .pop      (accept && need_rd),
        .pop_tag  (fl_tag),
        .push     (fl_push),
        .push_tag (commit_p_old),
`ifdef RENAME_FLUSH_EN
        .flush    (flush),
`endif
        .count    (fl_count)
    );

    always_comb begin
        rat_d          = rat_q;
        rename_valid_d = rename_valid_q;
        rename_pkt_d   = rename_pkt_q;
        if (accept) begin
            // Sources read rat_q, so rs==rd sees the mapping from before this write.
            rename_valid_d         = 1'b1;
            rename_pkt_d.opcode    = dec_pkt.opcode;
            rename_pkt_d.p_src1    = rat_q[dec_pkt.rs1];
            rename_pkt_d.p_src2    = rat_q[dec_pkt.rs2];
            rename_pkt_d.p_dst     = need_rd ? fl_tag : '0;
            rename_pkt_d.p_old_dst = need_rd ? rat_q[dec_pkt.rd] : '0;
            rename_pkt_d.arch_rd   = dec_pkt.rd;
            rename_pkt_d.has_rd    = dec_pkt.has_rd;
            if (need_rd) rat_d[dec_pkt.rd] = fl_tag;
        end else if (dispatch_ready) begin
            rename_valid_d = 1'b0;
            rename_pkt_d   = '0;
        end
`ifdef RENAME_FLUSH_EN
        rrat_d = rrat_q;
        if (fl_push) rrat_d[commit_arch_rd] = commit_p_dst;
        if (flush) begin
            rat_d          = rrat_d;
            rename_valid_d = 1'b0;
            rename_pkt_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
                rat_q[i] <= PREG_W'(i);
`ifdef RENAME_FLUSH_EN
                rrat_q[i] <= PREG_W'(i);
`endif
            end
            rename_valid_q <= 1'b0;
            rename_pkt_q   <= '0;
        end else begin
            rat_q          <= rat_d;
`ifdef RENAME_FLUSH_EN
            rrat_q         <= rrat_d;
`endif
            rename_valid_q <= rename_valid_d;
            rename_pkt_q   <= rename_pkt_d;
        end
    end

`ifndef SYNTHESIS
    fresh_commit_tag_a: assert property (@(posedge clk) disable iff (!reset)
        fl_push |-> (commit_p_dst != commit_p_old));
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: queue-based reference model plus a separate output monitor.
// RENAME_FLUSH_EN only adds a tied-off flush connection here.
module tb_rename_stage;
    import common_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                dec_valid = 1'b0;
    decode_packet_t      dec_pkt = '0;
    logic                dec_ready;
    logic                rename_valid;
    dispatch_packet_t    rename_pkt;
    logic                dispatch_ready = 1'b0;
    logic                commit_valid = 1'b0;
    logic                commit_has_rd = 1'b0;
    logic [AREG_W-1:0]   commit_arch_rd = '0;
    logic [PREG_W-1:0]   commit_p_dst = '0;
    logic [PREG_W-1:0]   commit_p_old = '0;
`ifdef RENAME_FLUSH_EN
    logic                flush = 1'b0;
`endif

    always #5 clk = ~clk;

    rename_stage dut (
        .clk            (clk),
        .reset          (reset),
        .dec_valid      (dec_valid),
        .dec_pkt        (dec_pkt),
        .dec_ready      (dec_ready),
        .rename_valid   (rename_valid),
        .rename_pkt     (rename_pkt),
        .dispatch_ready (dispatch_ready),
        .commit_valid   (commit_valid),
        .commit_has_rd  (commit_has_rd),
        .commit_arch_rd (commit_arch_rd),
        .commit_p_dst   (commit_p_dst),
        .commit_p_old   (commit_p_old)
`ifdef RENAME_FLUSH_EN
        ,
        .flush          (flush)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: architectural map, free-tag queue, slot occupancy, expected outputs.
    typedef struct { int unsigned rd; int unsigned pdst; int unsigned pold; } inflight_t;
    int unsigned       m_rat [ARCH_REGS];
    int unsigned       m_fl [$];
    bit                m_valid;
    dispatch_packet_t  sb [$];
    inflight_t         inflight [$];

    task automatic model_reset();
        for (int i = 0; i < ARCH_REGS; i++) m_rat[i] = i;
        m_fl.delete();
        for (int i = 0; i < FL_DEPTH; i++) m_fl.push_back(ARCH_REGS + i);
        m_valid = 0;
        sb.delete();
        inflight.delete();
    endtask

    task automatic evaluate();
        bit               need, exp_ready;
        dispatch_packet_t e;
        int unsigned      t;
        need      = dec_pkt.has_rd && (dec_pkt.rd != 0);
        exp_ready = (!m_valid || dispatch_ready) && (!need || m_fl.size() != 0);
        check("dec_ready", 64'(dec_ready), 64'(exp_ready));
        check("rename_valid", 64'(rename_valid), 64'(m_valid));
        if (dec_valid && exp_ready) begin
            e.opcode    = dec_pkt.opcode;
            e.p_src1    = PREG_W'(m_rat[dec_pkt.rs1]);
            e.p_src2    = PREG_W'(m_rat[dec_pkt.rs2]);
            e.arch_rd   = dec_pkt.rd;
            e.has_rd    = dec_pkt.has_rd;
            e.p_dst     = '0;
            e.p_old_dst = '0;
            if (need) begin
                t           = m_fl.pop_front();
                e.p_dst     = PREG_W'(t);
                e.p_old_dst = PREG_W'(m_rat[dec_pkt.rd]);
                inflight.push_back('{dec_pkt.rd, t, m_rat[dec_pkt.rd]});
                m_rat[dec_pkt.rd] = t;
            end
            sb.push_back(e);
            m_valid = 1;
        end else if (dispatch_ready) begin
            m_valid = 0;
        end
        if (commit_valid && commit_has_rd && commit_arch_rd != 0) m_fl.push_back(commit_p_old);
    endtask

    function automatic decode_packet_t mk(input int op, input int rs1, input int rs2, input int rd, input bit hr);
        decode_packet_t p;
        p.opcode = 7'(op);
        p.rs1    = AREG_W'(rs1);
        p.rs2    = AREG_W'(rs2);
        p.rd     = AREG_W'(rd);
        p.has_rd = hr;
        return p;
    endfunction

    task automatic step(input bit v, input decode_packet_t p, input bit dr,
                        input bit cv, input bit chr, input int crd, input int cpd, input int cpo);
        @(posedge clk);
        #1;
        dec_valid      = v;
        dec_pkt        = p;
        dispatch_ready = dr;
        commit_valid   = cv;
        commit_has_rd  = chr;
        commit_arch_rd = AREG_W'(crd);
        commit_p_dst   = PREG_W'(cpd);
        commit_p_old   = PREG_W'(cpo);
        @(negedge clk);
        evaluate();
    endtask

    task automatic hold_reset(input int cycles);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dec_valid = 1'b1;
        dec_pkt = mk(7'h13, 1, 2, 3, 1);
        dispatch_ready = 1'b1;
        commit_valid = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("reset_dec_ready", 64'(dec_ready), 64'(0));
            check("reset_rename_valid", 64'(rename_valid), 64'(0));
            check("reset_rename_pkt", 64'(rename_pkt), 64'(0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        dec_valid = 1'b0;
    endtask

    // Monitor: whenever the slot is valid, it must equal the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && rename_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(rename_valid), 64'(0));
                end else begin
                    check("rename_pkt", 64'(rename_pkt), 64'(sb[0]));
                    if (dispatch_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        decode_packet_t p;
        bit             v, dr, cv, chr;
        int             crd, cpd, cpo;
        inflight_t      f;

        hold_reset(3);

        // Rename of x5 twice, then a read of x5, then an rd=x0 writer.
        step(1, mk(7'h13, 5, 0, 5, 1), 1, 0, 0, 0, 0, 0);
        step(1, mk(7'h13, 5, 0, 5, 1), 1, 0, 0, 0, 0, 0);
        step(1, mk(7'h33, 5, 5, 0, 0), 1, 0, 0, 0, 0, 0);
        step(1, mk(7'h13, 3, 0, 0, 1), 1, 0, 0, 0, 0, 0);

        // Drain the remaining 30 free tags, then the next writer must stall.
        for (int i = 0; i < 30; i++) step(1, mk(7'h13, i, (i + 7) % 32, 6 + (i % 20), 1), 1, 0, 0, 0, 0, 0);
        repeat (3) step(1, mk(7'h13, 1, 2, 7, 1), 1, 0, 0, 0, 0, 0);
        step(1, mk(7'h13, 1, 2, 7, 1), 1, 1, 1, 5, 32, 5);
        step(1, mk(7'h13, 1, 2, 7, 1), 1, 0, 0, 0, 0, 0);

        // Backpressure: slot holds, no acceptance.
        repeat (3) step(1, mk(7'h33, 7, 5, 9, 0), 0, 0, 0, 0, 0, 0);
        step(1, mk(7'h33, 7, 5, 9, 0), 1, 0, 0, 0, 0, 0);
        step(0, mk(0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);

        // Reset with an instruction in the slot drops it.
        step(1, mk(7'h13, 4, 4, 4, 1), 0, 0, 0, 0, 0, 0);
        hold_reset(2);

        for (int c = 0; c < 3000; c++) begin
            p.opcode = 7'($urandom);
            p.rs1    = AREG_W'($urandom);
            p.rs2    = AREG_W'($urandom);
            p.rd     = AREG_W'($urandom);
            p.has_rd = ($urandom_range(0, 3) != 0);
            v   = ($urandom_range(0, 3) != 0);
            dr  = ($urandom_range(0, 3) != 0);
            cv  = 0;
            chr = 0;
            crd = 0;
            cpd = 0;
            cpo = 0;
            if (inflight.size() != 0 && $urandom_range(0, 2) == 0) begin
                f   = inflight.pop_front();
                cv  = 1;
                chr = 1;
                crd = f.rd;
                cpd = f.pdst;
                cpo = f.pold;
            end else if ($urandom_range(0, 7) == 0) begin
                cv  = 1;
                chr = $urandom_range(0, 1);
                crd = chr ? 0 : $urandom_range(0, 31);
                cpd = $urandom_range(0, 63);
                cpo = $urandom_range(0, 63);
            end
            step(v, p, dr, cv, chr, crd, cpd, cpo);
        end

        repeat (3) step(0, mk(0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
